// File: rtl/strobe_gen_pkg.sv
// Shared constants for the strobe generator: state encoding and default data width.
package strobe_pkg;

    localparam int STROBE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/strobe_gen.sv
// Programmable single-cycle strobe generator, continuous or burst of N strobes.
// Latency: first strobe_out in the cycle after edge k+P for start sampled at edge k.
// No backpressure: strobes are emitted unconditionally; downstream must accept every pulse.
module strobe_gen
    import strobe_pkg::*;
#(
    parameter int WIDTH          = STROBE_W,
    parameter int DEFAULT_PERIOD = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic             period_load,
    input  logic [WIDTH-1:0] period_in,
    input  logic [WIDTH-1:0] burst_len,
    output logic             strobe_out,
    output logic [WIDTH-1:0] phase,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] strobe_count
);

    localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_PERIOD = (DEFAULT_PERIOD < 1) ? ONE : WIDTH'(DEFAULT_PERIOD);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             cont_q, cont_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pend_d   = period_load ? ((period_in == '0) ? ONE : period_in) : pend_q;
        rem_d    = rem_q;
        cont_d   = cont_q;
        strobe_d = 1'b0;
        // done trails the final strobe by one cycle, so it is registered out of DONE.
        done_d   = (state_q == ST_DONE);
        count_d  = count_q;

        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start && !stop) begin
                    state_d = ST_RUN;
                    cnt_d   = pend_q - ONE;
                    rem_d   = burst_len;
                    cont_d  = (burst_len == '0);
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    rem_d   = '0;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    // Reload reads pend_q, so a coincident period_load lands one strobe later.
                    strobe_d = 1'b1;
                    count_d  = count_q + ONE;
                    if (!cont_q && rem_q == ONE) begin
                        state_d = ST_DONE;
                        cnt_d   = '0;
                        rem_d   = '0;
                    end else begin
                        cnt_d = pend_q - ONE;
                        if (!cont_q) begin
                            rem_d = rem_q - ONE;
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            pend_q   <= RST_PERIOD;
            rem_q    <= '0;
            cont_q   <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            pend_q   <= pend_d;
            rem_q    <= rem_d;
            cont_q   <= cont_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            count_q  <= count_d;
        end
    end

    assign strobe_out   = strobe_q;
    assign phase        = cnt_q;
    assign busy         = (state_q == ST_RUN);
    assign done         = done_q;
    assign strobe_count = count_q;

endmodule

// File: tb/tb_strobe_gen.sv
// Randomized + directed bench for strobe_gen; time-based reference model feeds a scoreboard.
module tb_strobe_gen;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start = 1'b0, stop = 1'b0, period_load = 1'b0;
    logic [W-1:0] period_in = '0, burst_len = '0;
    logic         strobe_out, busy, done;
    logic [W-1:0] phase, strobe_count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic         busy;
        logic [W-1:0] phase;
        logic         strobe;
        logic         done;
        logic [W-1:0] count;
    } stat_t;

    typedef struct {
        bit           is_done;
        logic [W-1:0] count;
    } evt_t;

    stat_t sq[$];
    evt_t  eq[$];

    strobe_gen #(.WIDTH(W), .DEFAULT_PERIOD(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .stop         (stop),
        .period_load  (period_load),
        .period_in    (period_in),
        .burst_len    (burst_len),
        .strobe_out   (strobe_out),
        .phase        (phase),
        .busy         (busy),
        .done         (done),
        .strobe_count (strobe_count)
    );

    always #5 clk = ~clk;

    // Reference model: tracks the absolute cycle of the next strobe instead of a counter.
    initial begin : model
        int           m_t, m_next;
        bit           m_run, m_fin, m_cont, strb, dn;
        logic [W-1:0] m_pend, m_rem, m_cnt, np;
        stat_t        s;
        m_t = 0; m_next = 0; m_run = 0; m_fin = 0; m_cont = 0;
        m_pend = 8'd4; m_rem = '0; m_cnt = '0;
        forever begin
            @(posedge clk);
            m_t++;
            strb = 0;
            dn   = 0;
            if (!rst_n) begin
                m_run = 0; m_fin = 0; m_cont = 0;
                m_pend = 8'd4; m_rem = '0; m_cnt = '0;
            end else begin
                np = period_load ? ((period_in == 0) ? 8'd1 : period_in) : m_pend;
                if (m_fin) begin
                    m_fin = 0;
                    dn    = 1;
                end else if (m_run) begin
                    if (stop) begin
                        m_run = 0;
                    end else if (m_t == m_next) begin
                        strb = 1;
                        m_cnt++;
                        if (!m_cont && m_rem == 1) begin
                            m_run = 0;
                            m_fin = 1;
                        end else begin
                            m_next = m_t + int'(m_pend);
                            if (!m_cont) m_rem--;
                        end
                    end
                end else if (start && !stop) begin
                    m_run  = 1;
                    m_next = m_t + int'(m_pend);
                    m_rem  = burst_len;
                    m_cont = (burst_len == 0);
                end
                m_pend = np;
            end
            s.busy   = m_run;
            s.phase  = m_run ? W'(m_next - m_t - 1) : '0;
            s.strobe = strb;
            s.done   = dn;
            s.count  = m_cnt;
            sq.push_back(s);
            if (strb || dn) eq.push_back('{dn, m_cnt});
        end
    end

    initial begin : monitor
        stat_t s;
        evt_t  e;
        forever begin
            @(negedge clk);
            if (sq.size() != 0) begin
                s = sq.pop_front();
                n_cmp++;
                if (busy !== s.busy || phase !== s.phase || strobe_out !== s.strobe ||
                    done !== s.done || strobe_count !== s.count) begin
                    n_bad++;
                    $display("FAIL status @%0t: got busy=%b phase=%0d strobe=%b done=%b count=%0d, want busy=%b phase=%0d strobe=%b done=%b count=%0d",
                             $time, busy, phase, strobe_out, done, strobe_count,
                             s.busy, s.phase, s.strobe, s.done, s.count);
                end
            end
            if (strobe_out === 1'b1 || done === 1'b1) begin
                n_cmp++;
                if (eq.size() == 0) begin
                    n_bad++;
                    $display("FAIL event @%0t: unexpected strobe=%b done=%b count=%0d, want no event",
                             $time, strobe_out, done, strobe_count);
                end else begin
                    e = eq.pop_front();
                    if (done !== e.is_done || strobe_out !== !e.is_done || strobe_count !== e.count) begin
                        n_bad++;
                        $display("FAIL event @%0t: got strobe=%b done=%b count=%0d, want done=%b count=%0d",
                                 $time, strobe_out, done, strobe_count, e.is_done, e.count);
                    end
                end
            end
        end
    end

    task automatic cyc(input bit st, input bit sp, input bit pl,
                       input logic [W-1:0] pin, input logic [W-1:0] bl);
        @(negedge clk);
        start = st; stop = sp; period_load = pl; period_in = pin; burst_len = bl;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, 0, 0, '0, '0);
    endtask

    task automatic check_reset_vals(input string name);
        n_cmp++;
        if (strobe_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || phase !== '0 || strobe_count !== '0) begin
            n_bad++;
            $display("FAIL %s: got strobe=%b busy=%b done=%b phase=%0d count=%0d, want all zero",
                     name, strobe_out, busy, done, phase, strobe_count);
        end
    endtask

    // Call just after a negedge: reset is asserted between edges to test async behaviour.
    task automatic reset_pulse();
        #1 rst_n = 1'b0;
        start = 0; stop = 0; period_load = 0; period_in = '0; burst_len = '0;
        #1 check_reset_vals("async_reset");
        @(negedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_phase(input logic [W-1:0] ph, input bit do_stop, output bit found);
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            start = 0; period_load = 0;
            found = (busy === 1'b1 && phase === ph);
            stop  = do_stop && found;
        end
        n_cmp++;
        if (!found) begin
            n_bad++;
            $display("FAIL wait_phase: phase %0d never reached while busy (got phase=%0d busy=%b)", ph, phase, busy);
        end
    endtask

    initial begin : stim
        bit found;
        int r;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_reset_vals("reset_state");
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;

        // continuous, period 3
        cyc(0, 0, 1, 8'd3, 8'd0);
        cyc(1, 0, 0, 8'd0, 8'd0);
        idle(14);
        cyc(0, 1, 0, 8'd0, 8'd0);
        idle(2);

        // burst of 2, period 5
        cyc(0, 0, 1, 8'd5, 8'd0);
        cyc(1, 0, 0, 8'd0, 8'd2);
        idle(14);

        // reprogram period mid-run
        cyc(0, 0, 1, 8'd4, 8'd0);
        cyc(1, 0, 0, 8'd0, 8'd0);
        idle(2);
        cyc(0, 0, 1, 8'd2, 8'd0);
        idle(10);
        cyc(0, 1, 0, 8'd0, 8'd0);
        idle(2);

        // stop on the strobe edge
        cyc(0, 0, 1, 8'd3, 8'd0);
        cyc(1, 0, 0, 8'd0, 8'd0);
        idle(4);
        wait_phase(8'd0, 1'b1, found);
        idle(3);

        // period 0 behaves as 1; count wraps
        cyc(0, 0, 1, 8'd0, 8'd0);
        cyc(1, 0, 0, 8'd0, 8'd0);
        idle(300);
        cyc(0, 1, 0, 8'd0, 8'd0);
        idle(2);

        // reset mid-run, then start on the default period
        cyc(0, 0, 1, 8'd6, 8'd0);
        cyc(1, 0, 0, 8'd0, 8'd0);
        wait_phase(8'd2, 1'b0, found);
        reset_pulse();
        cyc(1, 0, 0, 8'd0, 8'd1);
        idle(8);

        // start and stop together in IDLE
        cyc(1, 1, 0, 8'd0, 8'd0);
        idle(3);

        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                reset_pulse();
            end else begin
                cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 31) == 0),
                    ($urandom_range(0, 15) == 0), W'($urandom_range(0, 9)),
                    W'($urandom_range(0, 4)));
            end
        end

        idle(5);
        @(negedge clk);
        #1;
        n_cmp++;
        if (sq.size() != 0 || eq.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d status and %0d events left, want 0 and 0", sq.size(), eq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/strobe_gen.md
Name: strobe_gen

Overview:
Programmable single-cycle strobe generator: it produces the `strobe_in` pulse train consumed by the strobe counting/delay stage directly downstream.
- Emits one-clock-wide strobes every P clocks, either continuously or as a burst of N strobes.
- Reports phase, busy and done status.
- The period can be reprogrammed on the fly without glitches; a new period takes effect only at a strobe boundary.

Parameters:
WIDTH, 8, width of period, burst length, phase and strobe count
DEFAULT_PERIOD, 4, period loaded into the pending register at reset

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to begin strobing
stop  input  1  one-cycle request to abort strobing
period_load  input  1  capture period_in into the pending period register
period_in  input  WIDTH  requested period in clocks; 0 is treated as 1
burst_len  input  WIDTH  strobes per run, sampled at start; 0 means continuous
strobe_out  output  1  registered single-cycle strobe (feeds downstream strobe_in)
phase  output  WIDTH  current down-counter value; 0 in IDLE
busy  output  1  high in RUN
done  output  1  one-cycle pulse when a burst completes
strobe_count  output  WIDTH  total strobes emitted since reset, wraps mod 2^WIDTH

Behaviour:
- Reset (async assert, sync release) values:
  - strobe_out = 0, busy = 0, done = 0, phase = 0, strobe_count = 0.
  - state = IDLE, active_period = pending_period = max(DEFAULT_PERIOD, 1), remaining = 0.
- period_load (any state): pending_period <= (period_in == 0 ? 1 : period_in) at the next edge.
  - active_period copies pending_period only at start and at each strobe-producing edge.
  - If period_load and a strobe edge coincide, the strobe edge copies the old pending value; the new value applies from the following strobe.
- States:
  - IDLE: counter held at 0, busy = 0.
    - start = 1 and stop = 0 -> RUN.
    - On that edge: active_period <= pending_period; counter <= pending_period - 1; remaining <= burst_len; continuous <= (burst_len == 0).
  - RUN: busy = 1.
    - stop = 1 -> IDLE at the next edge. No strobe is emitted on that edge, even if counter == 0. Counter is cleared; remaining is cleared.
    - Else if counter != 0: counter decrements.
    - Else (counter == 0), the edge is a strobe edge:
      - strobe_out <= 1 for exactly one cycle; strobe_count increments; active_period <= pending_period; counter <= pending_period - 1.
      - If not continuous: remaining decrements. When remaining was 1 -> DONE instead of reloading.
    - start while in RUN is ignored.
  - DONE: done = 1 and busy = 0 for one cycle, then unconditionally -> IDLE. start and stop are ignored in DONE.
- Timing:
  - Latency: start sampled at edge k gives the first strobe_out high in the cycle following edge k+P. Later strobes are spaced exactly P cycles apart.
  - P = 1 gives strobe_out high every cycle, back to back.
  - The done pulse is in the cycle immediately after the final strobe's cycle.
- Counter arithmetic: unsigned WIDTH-bit. Maximum period is 2^WIDTH - 1. strobe_count wraps 2^WIDTH - 1 -> 0 with no flag.
- Simultaneous start and stop in IDLE: stop wins; the block stays IDLE.
- Asserting rst_n low mid-run immediately forces all reset values, including strobe_out = 0. No partial strobe is emitted.
- phase = counter value, for debug and alignment by the downstream consumer.

Decomposition:
- Shared package strobe_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - default-width constant STROBE_W = 8.
- The period down-counter with reload is small; keep it inline. No sub-module is warranted.
- The downstream strobe counter instantiates this block and connects strobe_out to its strobe_in.

Test Plan:
1. Reset, period_load with period_in = 3, start, burst_len = 0 -> strobe_out pulses 3 cycles after start and then every 3 cycles; strobe_count = 4 after 4 pulses; busy stays 1.
2. burst_len = 2, period 5, start -> exactly 2 strobes 5 cycles apart, then done = 1 the next cycle, busy = 0, state IDLE; strobe_count = 2.
3. Running with period 4, period_load period_in = 2 mid-period -> the next strobe still arrives at 4 cycles; subsequent strobes are spaced 2 cycles apart.
4. Running with period 3, stop asserted on the cycle where phase = 0 -> no strobe emitted, busy = 0 next cycle, phase = 0.
5. period_in = 0, start, burst_len = 0 -> strobe_out high every cycle; after 256 strobes strobe_count wraps to 0.
6. rst_n pulsed low mid-run with phase = 2 -> outputs immediately at reset values; the next start uses pending_period = 4.
